// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction field layout, opcode/aluop
// constants and the multdiv sequencer state encoding.
package pipe_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;

  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [31:0] NOP = 32'b0;

  // Field view of a 32-bit instruction, MSB first.
  typedef struct packed {
    logic [4:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] shamt;
    logic [4:0] aluop;
    logic [1:0] pad;
  } ir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline datapath.
// slave = the controller, master = the datapath side driving IRs/status.
interface pipe_hazard_ctrl_if;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        branch_taken;
  logic        md_result_rdy;
  logic        md_exception;

  logic pc_en, fd_en, dx_en, xm_en, mw_en;
  logic fd_nop, dx_nop, xm_nop;
  logic md_ctrl_mult, md_ctrl_div;
  logic md_sel, md_ovf, md_timeout;

  modport master (
    output fd_ir, dx_ir, branch_taken, md_result_rdy, md_exception,
    input  pc_en, fd_en, dx_en, xm_en, mw_en,
    input  fd_nop, dx_nop, xm_nop,
    input  md_ctrl_mult, md_ctrl_div,
    input  md_sel, md_ovf, md_timeout
  );

  modport slave (
    input  fd_ir, dx_ir, branch_taken, md_result_rdy, md_exception,
    output pc_en, fd_en, dx_en, xm_en, mw_en,
    output fd_nop, dx_nop, xm_nop,
    output md_ctrl_mult, md_ctrl_div,
    output md_sel, md_ovf, md_timeout
  );
endinterface

// File: rtl/ir_src_decode.sv
// Maps an instruction to the register numbers it may read and flags telling
// which of them it actually reads. Shared with the bypass unit.
module ir_src_decode
  import pipe_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        use_rs,
  output logic        use_rt,
  output logic        use_rd
);

  ir_t f;
  logic unused_fields;

  assign f  = ir_t'(ir);
  assign rs = f.rs;
  assign rt = f.rt;
  assign rd = f.rd;
  assign unused_fields = ^{f.shamt, f.aluop, f.pad};

  // Per-opcode source usage; sw/bne/blt/jr read their rd field as a source.
  always_comb begin
    // NOTE: every output written here gets a default first, so no path through the case infers a latch.
    use_rs = 1'b0;
    use_rt = 1'b0;
    use_rd = 1'b0;
    case (f.opcode)
      OP_RTYPE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_ADDI, OP_LW: use_rs = 1'b1;
      OP_SW, OP_BNE, OP_BLT: begin
        use_rs = 1'b1;
        use_rd = 1'b1;
      end
      OP_JR:   use_rd = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles,
// taken-branch squashing, and the multdiv START/BUSY/DONE freeze.
// CNT_W must satisfy 2**CNT_W > MD_TIMEOUT.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input logic              clock,
  input logic              reset_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_div_q;   // op kind latched so start pulses never glitch with dx_ir
  logic             ovf_q;
  logic             timeout_q;

  ir_t  dx;
  logic unused_dx;
  logic dx_is_md, dx_is_div, dx_is_load;
  logic [4:0] fd_rs, fd_rt, fd_rd;
  logic fd_use_rs, fd_use_rt, fd_use_rd;
  logic load_use;
  logic freeze;

  ir_src_decode u_fd_src (
    .ir     (hz.fd_ir),
    .rs     (fd_rs),
    .rt     (fd_rt),
    .rd     (fd_rd),
    .use_rs (fd_use_rs),
    .use_rt (fd_use_rt),
    .use_rd (fd_use_rd)
  );

  assign dx         = ir_t'(hz.dx_ir);
  assign unused_dx  = ^{dx.rs, dx.rt, dx.shamt, dx.pad};
  assign dx_is_div  = (dx.opcode == OP_RTYPE) && (dx.aluop == ALU_DIV);
  assign dx_is_md   = (dx.opcode == OP_RTYPE) && ((dx.aluop == ALU_MUL) || (dx.aluop == ALU_DIV));
  assign dx_is_load = (dx.opcode == OP_LW);

  // r0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = dx_is_load && (dx.rd != 5'd0) &&
                    ((fd_use_rs && (fd_rs == dx.rd)) ||
                     (fd_use_rt && (fd_rt == dx.rd)) ||
                     (fd_use_rd && (fd_rd == dx.rd)));

  assign hz.md_timeout = timeout_q;

  // State, BUSY counter and the multdiv status captured on leaving BUSY.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_div_q  <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking (<=) so every register here sees pre-edge values of the others.
      state <= state_nxt;
      case (state)
        IDLE:  op_div_q <= dx_is_div;
        START: cnt <= '0;
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (hz.md_result_rdy) begin
            ovf_q <= hz.md_exception;
          end else if (cnt == CNT_LAST) begin
            ovf_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and latch controls; multdiv freeze beats branch beats load-use.
  always_comb begin
    state_nxt       = state;
    freeze          = 1'b0;
    hz.pc_en        = 1'b1;
    hz.fd_en        = 1'b1;
    hz.dx_en        = 1'b1;
    hz.xm_en        = 1'b1;
    hz.mw_en        = 1'b1;
    hz.fd_nop       = 1'b0;
    hz.dx_nop       = 1'b0;
    hz.xm_nop       = 1'b0;
    hz.md_ctrl_mult = 1'b0;
    hz.md_ctrl_div  = 1'b0;
    hz.md_sel       = 1'b0;
    hz.md_ovf       = 1'b0;

    case (state)
      IDLE: begin
        if (dx_is_md) begin
          // Hold the mult/div in dx until its result is written in DONE.
          state_nxt = START;
          freeze    = 1'b1;
        end else if (hz.branch_taken) begin
          hz.fd_nop = 1'b1;
          hz.dx_nop = 1'b1;
        end else if (load_use) begin
          hz.pc_en  = 1'b0;
          hz.fd_en  = 1'b0;
          hz.dx_nop = 1'b1;
        end
      end
      START: begin
        state_nxt       = BUSY;
        freeze          = 1'b1;
        hz.md_ctrl_mult = !op_div_q;
        hz.md_ctrl_div  = op_div_q;
      end
      BUSY: begin
        freeze = 1'b1;
        if (hz.md_result_rdy || (cnt == CNT_LAST)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        hz.md_sel = 1'b1;
        hz.md_ovf = ovf_q;
      end
      default: state_nxt = IDLE;
    endcase

    // Front of the pipe holds; older instructions drain behind a NOP in X/M.
    if (freeze) begin
      hz.pc_en  = 1'b0;
      hz.fd_en  = 1'b0;
      hz.dx_en  = 1'b0;
      hz.xm_nop = 1'b1;
    end
  end

endmodule
